// File: rtl/ct_f_spsram_param_if.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_param_if
// Bus bundle for the single-port SRAM model.
//   A         word address
//   CEN       chip enable, active low
//   GWEN      global write enable, active low (0 = write, 1 = read)
//   WEN       per-bit write enable, active low
//   D         write data
//   Q         read data
//   INIT_BUSY high while the post-reset zero-fill runs
// master: the requester (drives A/CEN/GWEN/WEN/D).
// slave : the memory (drives Q/INIT_BUSY).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ct_f_spsram_param_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_BUSY;

  modport master (output A, CEN, GWEN, WEN, D, input Q, INIT_BUSY);
  modport slave  (input A, CEN, GWEN, WEN, D, output Q, INIT_BUSY);
endinterface

// File: rtl/ct_f_spsram_param.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_param
// Parameterised single-port SRAM with per-bit write mask, write-first read
// data, optional output register and an optional zero-fill after reset.
// Ports:
//   CLK  single clock, all state on the rising edge
//   RST  asynchronous active-high reset
//   bus  slave side of ct_f_spsram_param_if (A, CEN, GWEN, WEN, D, Q,
//        INIT_BUSY)
// Parameters:
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  word width
//   OUT_REG     0: read latency 1, 1: extra output stage, latency 2
//   INIT_CLEAR  1: zero-fill the array after reset, 0: no fill
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_param_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic [DATA_WIDTH-1:0] q2_q, q2_d;
  logic                  valid1_q, valid1_d;

  logic                  access;
  logic                  wr_access;
  logic                  clr_wr;
  logic [ADDR_WIDTH-1:0] addr_int;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: every always_comb output gets a default first so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    // RST gates both array write paths so an edge that lands inside reset
    // neither completes a pending access nor advances the fill.
    access    = !bus.CEN && (state_q == ST_READY) && !RST;
    wr_access = access && !bus.GWEN;
    clr_wr    = (state_q == ST_CLEAR) && !RST;

    addr_int  = access ? bus.A : addr_q;
    rd_word   = mem[addr_int];
    // Bits with WEN=0 take D, bits with WEN=1 keep the stored value.
    wr_word   = (rd_word & bus.WEN) | (bus.D & ~bus.WEN);

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    valid1_d  = access;

    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // The edge that clears the last word also leaves CLEAR.
      if (&cnt_q) state_d = ST_READY;
    end

    if (access) begin
      addr_d = bus.A;
      // Write-first: a write cycle returns the merged post-write word.
      q1_d   = bus.GWEN ? rd_word : wr_word;
    end

    // Output stage only follows stage 1 when stage 1 was loaded by an access.
    if (valid1_q) q2_d = q1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      addr_q   <= '0;
      q1_q     <= '0;
      q2_q     <= '0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      valid1_q <= valid1_d;
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the fill FSM,
  // and a reset port here would prevent mapping onto a RAM macro.
  always_ff @(posedge CLK) begin
    if (clr_wr) begin
      mem[cnt_q] <= '0;
    end else if (wr_access) begin
      mem[bus.A] <= wr_word;
    end
  end

  assign bus.Q         = (OUT_REG != 0) ? q2_q : q1_q;
  assign bus.INIT_BUSY = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// ----------------------------------------------------------------------------
// tb_ct_f_spsram_param
// Directed bench for ct_f_spsram_param. Three instances share CLK/RST:
//   u_dut0  defaults (10/32, OUT_REG=0, INIT_CLEAR=1)
//   u_dut1  OUT_REG=1, otherwise defaults
//   u_dut2  ADDR_WIDTH=4, DATA_WIDTH=13, INIT_CLEAR=0
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ct_f_spsram_param;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  ct_f_spsram_param_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();
  ct_f_spsram_param_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();
  ct_f_spsram_param_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(13)) bus2 ();

  ct_f_spsram_param #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(0), .INIT_CLEAR(1))
    u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  ct_f_spsram_param #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(1), .INIT_CLEAR(1))
    u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  ct_f_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(13), .OUT_REG(0), .INIT_CLEAR(0))
    u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  int tests_run = 0;
  int tests_failed = 0;
  int busy2_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Per-bus drivers
  task automatic idle0();
    bus0.CEN = 1'b1; bus0.GWEN = 1'b1; bus0.WEN = '1; bus0.D = '0; bus0.A = '0;
  endtask
  task automatic wr0(input logic [9:0] a, input logic [31:0] d, input logic [31:0] wen);
    bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.A = a; bus0.D = d; bus0.WEN = wen;
  endtask
  task automatic rd0(input logic [9:0] a);
    bus0.CEN = 1'b0; bus0.GWEN = 1'b1; bus0.A = a; bus0.D = '0; bus0.WEN = '1;
  endtask
  task automatic idle1();
    bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = '1; bus1.D = '0; bus1.A = '0;
  endtask
  task automatic wr1(input logic [9:0] a, input logic [31:0] d);
    bus1.CEN = 1'b0; bus1.GWEN = 1'b0; bus1.A = a; bus1.D = d; bus1.WEN = '0;
  endtask
  task automatic rd1(input logic [9:0] a);
    bus1.CEN = 1'b0; bus1.GWEN = 1'b1; bus1.A = a; bus1.D = '0; bus1.WEN = '1;
  endtask
  task automatic idle2();
    bus2.CEN = 1'b1; bus2.GWEN = 1'b1; bus2.WEN = '1; bus2.D = '0; bus2.A = '0;
  endtask
  task automatic wr2(input logic [3:0] a, input logic [12:0] d);
    bus2.CEN = 1'b0; bus2.GWEN = 1'b0; bus2.A = a; bus2.D = d; bus2.WEN = '0;
  endtask
  task automatic rd2(input logic [3:0] a);
    bus2.CEN = 1'b0; bus2.GWEN = 1'b1; bus2.A = a; bus2.D = '0; bus2.WEN = '1;
  endtask

  // Pattern for the small instance: 0x2A5 is odd, so 16 products are distinct.
  function automatic logic [12:0] pat(input int i);
    return 13'((i * 32'h2A5 + 32'h111) & 32'h1FFF);
  endfunction

  // The INIT_CLEAR=0 instance must never report busy.
  always @(negedge CLK) if (bus2.INIT_BUSY !== 1'b0) busy2_seen++;

  initial begin
    int n;
    int bad;

    RST = 1'b1;
    idle0(); idle1(); idle2();
    repeat (3) step();
    check("reset_q0", 64'(bus0.Q), 64'h0);
    check("reset_q1", 64'(bus1.Q), 64'h0);
    check("reset_q2", 64'(bus2.Q), 64'h0);
    check("reset_busy0", 64'(bus0.INIT_BUSY), 64'h1);
    check("reset_busy2", 64'(bus2.INIT_BUSY), 64'h0);

    // First fill, interrupted by reset after 500 cycles.
    RST = 1'b0;
    check("busy_after_release", 64'(bus0.INIT_BUSY), 64'h1);
    repeat (500) step();
    check("busy_at_500", 64'(bus0.INIT_BUSY), 64'h1);
    RST = 1'b1;
    #1;
    check("midfill_rst_busy", 64'(bus0.INIT_BUSY), 64'h1);
    check("midfill_rst_q", 64'(bus0.Q), 64'h0);
    step();
    RST = 1'b0;

    // Full refill; a write to address 5 attempted late in the fill is lost.
    n = 0;
    while (bus0.INIT_BUSY && n < 2000) begin
      if (n == 1000) wr0(10'd5, 32'hFFFF_FFFF, 32'h0);
      step();
      if (n == 1000) idle0();
      n++;
    end
    check("fill_cycles", 64'(n), 64'd1024);
    check("fill_done_busy1", 64'(bus1.INIT_BUSY), 64'h0);

    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      rd0(10'(a));
      step();
      if (bus0.Q !== 32'h0) bad++;
    end
    check("read_all_zero_bad_count", 64'(bad), 64'd0);
    rd0(10'd5); step();
    check("fill_write_lost", 64'(bus0.Q), 64'h0);

    // Partial-mask write with write-first read data.
    wr0(10'h3FF, 32'hDEAD_BEEF, 32'h0); step();
    check("wr_full_q", 64'(bus0.Q), 64'hDEAD_BEEF);
    wr0(10'h3FF, 32'h1234_5678, 32'hFFFF_0000); step();
    check("wr_mask_q", 64'(bus0.Q), 64'hDEAD_5678);
    rd0(10'h3FF); step();
    check("rd_mask_q", 64'(bus0.Q), 64'hDEAD_5678);

    // Write with all WEN high: no change, but still an access.
    rd0(10'h000); step();
    check("rd_zero_q", 64'(bus0.Q), 64'h0);
    wr0(10'h3FF, 32'h0, 32'hFFFF_FFFF); step();
    check("wen_ones_q", 64'(bus0.Q), 64'hDEAD_5678);
    rd0(10'h3FF); step();
    check("wen_ones_mem", 64'(bus0.Q), 64'hDEAD_5678);

    // Write then read same address, then idle with a different A.
    wr0(10'd5, 32'h1, 32'h0); step();
    rd0(10'd5); step();
    check("raw_q", 64'(bus0.Q), 64'h1);
    idle0(); bus0.A = 10'd7; step();
    check("idle_hold_q", 64'(bus0.Q), 64'h1);
    step();
    check("idle_hold_q2", 64'(bus0.Q), 64'h1);
    idle0();

    // Output-register instance: two-cycle latency, hold on idle.
    wr1(10'h010, 32'hA5A5_A5A5); step();
    wr1(10'h011, 32'h0F0F_0F0F); step();
    idle1(); step(); step();
    check("oreg_prev_q", 64'(bus1.Q), 64'h0F0F_0F0F);
    rd1(10'h010); step();
    check("oreg_edge1_q", 64'(bus1.Q), 64'h0F0F_0F0F);
    idle1(); step();
    check("oreg_edge2_q", 64'(bus1.Q), 64'hA5A5_A5A5);
    step();
    check("oreg_idle1_q", 64'(bus1.Q), 64'hA5A5_A5A5);
    step();
    check("oreg_idle2_q", 64'(bus1.Q), 64'hA5A5_A5A5);

    // Narrow instance without fill: 16 distinct patterns written then read.
    for (int i = 0; i < 16; i++) begin
      wr2(4'(i), pat(i)); step();
    end
    for (int i = 0; i < 16; i++) begin
      rd2(4'(i)); step();
      check($sformatf("small_rd_%0d", i), 64'(bus2.Q), 64'(pat(i)));
    end

    // Reset landing on a pending write: write discarded, Q cleared at once.
    wr2(4'd3, 13'h1FFF); bus2.WEN = '0;
    #2;
    RST = 1'b1;
    #1;
    check("rst_access_q", 64'(bus2.Q), 64'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle2(); idle0(); idle1();
    check("rst_access_q_after", 64'(bus2.Q), 64'h0);
    rd2(4'd3); step();
    check("rst_access_discarded", 64'(bus2.Q), 64'(pat(3)));
    idle2(); step();

    check("small_busy_never", 64'(busy2_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
